dimc_18_fixed: RTL and testbench
================================

DIMC_18_FIXED -- requirements
Module: dimc_18_fixed

Interface
REQ-001 One clock; reset is synchronous and active-low. Clock is RCK; reset is RESETn.
REQ-002 RCK  in  1  sole clock; all state updates on the RCK rising edge.
REQ-003 RESETn  in  1  synchronous active-low reset.
REQ-004 WCK  in  1  write clock, tied to RCK by the integrator; functionally unused.
REQ-005 D, WA, WEN, WCSN, M  in  256/7/1/1/256  array write data, row address, write enable (active low), write select (active low), per-bit write mask (1 = write).
REQ-006 RA, RCSN  in  7/1  array read/compute row address and read select (active low).
REQ-007 RCSN0..RCSN3  in  1 each  compute kernel-section enables (active low).
REQ-008 FD, FA, FCSN  in  256/2/1  feature data, feature section, feature write select (active low).
REQ-009 COMPE, MODE, ADDIN, MCT  in  1/2/24/8  compute enable, precision mode, partial-sum input, output shift control.
REQ-010 Q  out  256  array read data.
REQ-011 PSOUT  out  24  MAC partial sum.
REQ-012 RES_OUT, SOUT  out  3/1  quantized result, bits [3:1] and [0].
REQ-013 READYN  out  1  result-valid strobe (active low).

Function
REQ-014 Array: 128 rows x 256 bits; row address = {row[4:0], section[1:0]}.
REQ-015 Write: WCSN=0 and WEN=0 at an edge -> for each bit i with M[i]=1, row[WA][i] <= D[i]; other bits unchanged.
REQ-016 Read: RCSN=0 and COMPE=0 at an edge -> Q <= row[RA] at that same edge; Q holds otherwise (1-cycle latency).
REQ-017 Same-row simultaneous read/write: Q and compute return the pre-write contents.
REQ-018 Feature buffer: 4 x 256 bits; FCSN=0 at an edge -> feature[FA] <= FD; concatenated feature F = {f3,f2,f1,f0}, 1024 bits.
REQ-019 Compute request: COMPE=1 and RCSN=0 at edge N. Kernel K = {row[{RA[6:2],3}], ..2, ..1, ..0}; a section k with RCSNk=1 contributes zeros.
REQ-020 MODE 00: sum = popcount(K AND F) (1024 one-bit lanes).
REQ-021 MODE 01: 512 unsigned 2-bit lanes. MODE 10: 256 unsigned 4-bit lanes. MODE 11: 128 unsigned 8-bit lanes. Lane j = bits aligned in K and F; sum = sum of Kj*Fj.
REQ-022 PSOUT = sum + ADDIN, modulo 2^24.
REQ-023 q = min(PSOUT >> MCT[4:0], 15); {RES_OUT, SOUT} = q[3:0].
REQ-024 Pipeline: 3 register stages (operand capture, lane products/partial trees, final add/quantize). PSOUT/RES_OUT/SOUT update and READYN=0 at edge N+3.
REQ-025 4-cycle latency from the cycle the request is driven to READYN low.
REQ-026 READYN is low for exactly one cycle per request; back-to-back requests on consecutive edges give consecutive one-cycle READYN pulses (throughput 1/cycle).
REQ-027 Outputs hold their last value while READYN=1.
REQ-028 Operands (array, feature, MODE, ADDIN, MCT) are sampled at edge N; later writes do not affect an in-flight request.

Reset
REQ-029 RESETn=0 at an edge: Q=0, PSOUT=0, RES_OUT=0, SOUT=0, READYN=1, all pipeline valid bits cleared. In-flight requests are discarded, with no READYN pulse.
REQ-030 Array and feature contents are not reset.
REQ-031 During reset, writes and compute requests are ignored.

Verification
REQ-032 Write row 0 = 0x…A5A5 (128-bit pattern, upper bits 0), M=all-ones -> read RA=0 -> Q equals the pattern one edge later.
REQ-033 Masked write with M=0x0F over existing 0xFF, D=0x00 -> Q=0xF0.
REQ-034 Kernel and feature all ones, MODE 00, ADDIN=0, MCT=0 -> PSOUT=1024, {RES_OUT,SOUT}=1111, READYN low 40 ns after the request is driven.
REQ-035 Five consecutive requests (rows 0..4, MODE 00, all ones) -> five READYN pulses 10 ns apart, each PSOUT=1024.
REQ-036 MODE 10, K lane0=1, F lane0=1, all other lanes 0, ADDIN=5 -> PSOUT=6, q=0110. Repeat with MCT=1 -> q=0011.
REQ-037 Assert RESETn=0 one cycle after a request -> no READYN pulse; PSOUT=0.

Source files
------------

// File: rtl/dimc_18_fixed.sv
// dimc_18_fixed: 128x256 array with a 4x256 feature buffer and a pipelined
// multi-precision MAC over a 1024-bit kernel, followed by a 4-bit quantizer.

module dimc_18_fixed_lane #(
    parameter int VEC_W = 8
) (
    input  logic [1:0]         mode,
    input  logic [VEC_W-1:0]   k,
    input  logic [VEC_W-1:0]   f,
    output logic [2*VEC_W-1:0] prod
);
    localparam int PW = 2 * VEC_W;

    logic [PW-1:0] p1, p2, p4, p8;

    // One byte lane holds 8x1, 4x2, 2x4 or 1x8-bit sub-lanes depending on mode.
    always_comb begin
        p1 = '0;
        p2 = '0;
        p4 = '0;
        p8 = '0;
        for (int i = 0; i < VEC_W; i++)
            p1 = p1 + PW'(k[i] & f[i]);
        for (int i = 0; i < VEC_W / 2; i++)
            p2 = p2 + PW'(k[2*i +: 2]) * PW'(f[2*i +: 2]);
        for (int i = 0; i < VEC_W / 4; i++)
            p4 = p4 + PW'(k[4*i +: 4]) * PW'(f[4*i +: 4]);
        for (int i = 0; i < VEC_W / 8; i++)
            p8 = p8 + PW'(k[8*i +: 8]) * PW'(f[8*i +: 8]);
    end

    always_comb begin
        prod = p1;
        case (mode)
            2'b01:   prod = p2;
            2'b10:   prod = p4;
            2'b11:   prod = p8;
            default: prod = p1;
        endcase
    end
endmodule

module dimc_18_fixed #(
    parameter int NUM_LANES = 128,
    parameter int VEC_W     = 8
) (
    input  logic         RCK,
    input  logic         RESETn,
    input  logic         WCK,
    input  logic [255:0] D,
    input  logic [6:0]   WA,
    input  logic         WEN,
    input  logic         WCSN,
    input  logic [255:0] M,
    input  logic [6:0]   RA,
    input  logic         RCSN,
    input  logic         RCSN0,
    input  logic         RCSN1,
    input  logic         RCSN2,
    input  logic         RCSN3,
    input  logic [255:0] FD,
    input  logic [1:0]   FA,
    input  logic         FCSN,
    input  logic         COMPE,
    input  logic [1:0]   MODE,
    input  logic [23:0]  ADDIN,
    input  logic [7:0]   MCT,
    output logic [255:0] Q,
    output logic [23:0]  PSOUT,
    output logic [2:0]   RES_OUT,
    output logic         SOUT,
    output logic         READYN
);
    localparam int ROWS   = 128;
    localparam int RW     = 256;
    localparam int SECS   = 4;
    localparam int STAGES = 3;
    localparam int LPS    = NUM_LANES / SECS;
    localparam int PW     = 2 * VEC_W;

    typedef struct packed {
        logic [1:0]  mode;
        logic [23:0] addin;
        logic [4:0]  sh;
    } ctl_t;

    logic [RW-1:0]                   mem [ROWS];
    logic [SECS-1:0][RW-1:0]         feat;
    logic [STAGES:0]                 vld_pipe;
    logic [NUM_LANES-1:0][VEC_W-1:0] s1_k, s1_f;
    ctl_t                            s1_ctl, s2_ctl;
    logic [SECS-1:0][23:0]           s2_sec;
    logic [23:0]                     s3_ps;
    logic [4:0]                      s3_sh;
    logic [NUM_LANES-1:0][PW-1:0]    prod;
    logic [SECS-1:0][23:0]           sec_sum;
    logic [SECS*RW-1:0]              kern;
    logic [SECS-1:0]                 sec_off;
    logic [23:0]                     shifted;
    logic [3:0]                      quant;
    logic                            wr, rd, req;
    logic                            unused_bits;

    assign wr          = ~WCSN & ~WEN;
    assign rd          = ~RCSN & ~COMPE;
    assign req         = ~RCSN & COMPE;
    assign sec_off     = {RCSN3, RCSN2, RCSN1, RCSN0};
    assign unused_bits = ^{WCK, MCT[7:5]};

    // Kernel gathers the four section rows sharing RA[6:2]; disabled sections read as zero.
    always_comb begin
        kern = '0;
        for (int s = 0; s < SECS; s++)
            kern[s*RW +: RW] = sec_off[s] ? '0 : mem[{RA[6:2], 2'(s)}];
    end

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        dimc_18_fixed_lane #(.VEC_W(VEC_W)) u_lane (
            .mode (s1_ctl.mode),
            .k    (s1_k[j]),
            .f    (s1_f[j]),
            .prod (prod[j])
        );
    end

    always_comb begin
        sec_sum = '0;
        for (int s = 0; s < SECS; s++)
            for (int j = 0; j < LPS; j++)
                sec_sum[s] = sec_sum[s] + 24'(prod[s*LPS + j]);
    end

    assign shifted = s3_ps >> s3_sh;
    assign quant   = (shifted > 24'd15) ? 4'hF : shifted[3:0];

    // Storage and datapath stages carry no reset; only the valid pipe qualifies them.
    always_ff @(posedge RCK) begin
        if (RESETn && wr)
            mem[WA] <= (mem[WA] & ~M) | (D & M);
        if (RESETn && !FCSN)
            feat[FA] <= FD;
        if (req) begin
            s1_k   <= kern;
            s1_f   <= feat;
            s1_ctl <= '{MODE, ADDIN, MCT[4:0]};
        end
        if (vld_pipe[0]) begin
            s2_sec <= sec_sum;
            s2_ctl <= s1_ctl;
        end
        if (vld_pipe[1]) begin
            s3_ps <= s2_sec[0] + s2_sec[1] + s2_sec[2] + s2_sec[3] + s2_ctl.addin;
            s3_sh <= s2_ctl.sh;
        end
    end

    always_ff @(posedge RCK) begin
        if (!RESETn) begin
            vld_pipe <= '0;
            Q        <= '0;
            PSOUT    <= '0;
            RES_OUT  <= '0;
            SOUT     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], req};
            if (rd)
                Q <= mem[RA];
            if (vld_pipe[STAGES-1]) begin
                PSOUT          <= s3_ps;
                {RES_OUT, SOUT} <= quant;
            end
        end
    end

    assign READYN = ~vld_pipe[STAGES];
endmodule

// File: tb/tb_dimc_18_fixed.sv
// Self-checking bench for dimc_18_fixed: directed spec cases plus random traffic
// scored against a lane-arithmetic reference model.
module tb_dimc_18_fixed;
    logic         RCK = 1'b0;
    logic         RESETn, WCK;
    logic [255:0] D, M, FD, Q;
    logic [6:0]   WA, RA;
    logic         WEN, WCSN, RCSN, FCSN, COMPE, SOUT, READYN;
    logic [3:0]   rcsn_sec;
    logic [1:0]   FA, MODE;
    logic [23:0]  ADDIN, PSOUT;
    logic [7:0]   MCT;
    logic [2:0]   RES_OUT;

    always #5 RCK = ~RCK;
    assign WCK = RCK;

    dimc_18_fixed dut (
        .RCK(RCK), .RESETn(RESETn), .WCK(WCK), .D(D), .WA(WA), .WEN(WEN), .WCSN(WCSN), .M(M),
        .RA(RA), .RCSN(RCSN), .RCSN0(rcsn_sec[0]), .RCSN1(rcsn_sec[1]), .RCSN2(rcsn_sec[2]),
        .RCSN3(rcsn_sec[3]), .FD(FD), .FA(FA), .FCSN(FCSN), .COMPE(COMPE), .MODE(MODE),
        .ADDIN(ADDIN), .MCT(MCT), .Q(Q), .PSOUT(PSOUT), .RES_OUT(RES_OUT), .SOUT(SOUT),
        .READYN(READYN)
    );

    typedef struct {
        int          due;
        logic [23:0] ps;
        logic [3:0]  q;
    } exp_t;

    logic [255:0] mem_m [128];
    logic [255:0] feat_m [4];
    exp_t         due_q [$];
    int           cyc, n_cmp, n_bad;
    logic [255:0] exp_q, saved;
    logic [23:0]  exp_ps;
    logic [3:0]   exp_res;
    logic         exp_rdy;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Sum of products over (1024 >> mode) lanes of width (1 << mode).
    function automatic logic [23:0] mac(logic [1023:0] k, logic [1023:0] f, logic [1:0] mode);
        int     w    = 1 << mode;
        longint mask = (longint'(1) << w) - 1;
        longint s    = 0;
        for (int j = 0; j < 1024 / w; j++) begin
            s += (longint'(k[7:0]) & mask) * (longint'(f[7:0]) & mask);
            k = k >> w;
            f = f >> w;
        end
        return 24'(s);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        WEN = 1; WCSN = 1; RCSN = 1; COMPE = 0; FCSN = 1; rcsn_sec = 4'h0;
        D = '0; M = '0; WA = '0; RA = '0; FD = '0; FA = '0; MODE = '0; ADDIN = '0; MCT = '0;
    endtask

    // Model the coming edge from the driven inputs, clock it, then score every output.
    task automatic step();
        logic [1023:0] kk, ff;
        logic [23:0]   ps, sh;
        exp_t          e;
        if (!RESETn) begin
            exp_q = '0; exp_ps = '0; exp_res = '0;
            due_q.delete();
        end else begin
            if (!RCSN && !COMPE) exp_q = mem_m[RA];
            if (!RCSN && COMPE) begin
                for (int s = 0; s < 4; s++) begin
                    kk[s*256 +: 256] = rcsn_sec[s] ? '0 : mem_m[{RA[6:2], 2'(s)}];
                    ff[s*256 +: 256] = feat_m[s];
                end
                ps    = mac(kk, ff, MODE) + ADDIN;
                sh    = ps >> MCT[4:0];
                e.due = cyc + 4;
                e.ps  = ps;
                e.q   = (sh > 24'd15) ? 4'hF : sh[3:0];
                due_q.push_back(e);
            end
            if (!WCSN && !WEN) mem_m[WA] = (mem_m[WA] & ~M) | (D & M);
            if (!FCSN) feat_m[FA] = FD;
        end
        @(posedge RCK);
        #1;
        cyc++;
        exp_rdy = 1'b1;
        if (due_q.size() > 0 && due_q[0].due == cyc) begin
            e = due_q.pop_front();
            exp_ps = e.ps; exp_res = e.q; exp_rdy = 1'b0;
        end
        chk("Q", Q, exp_q);
        chk("READYN", READYN, exp_rdy);
        chk("PSOUT", PSOUT, exp_ps);
        chk("RES", {RES_OUT, SOUT}, exp_res);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [255:0] d, input logic [255:0] m);
        WCSN = 0; WEN = 0; WA = a; D = d; M = m;
        step(); idle();
    endtask

    task automatic do_feat(input logic [1:0] a, input logic [255:0] d);
        FCSN = 0; FA = a; FD = d;
        step(); idle();
    endtask

    task automatic do_read(input logic [6:0] a);
        RCSN = 0; COMPE = 0; RA = a;
        step(); idle();
    endtask

    task automatic do_req(input logic [6:0] a, input logic [1:0] md, input logic [23:0] add,
                          input logic [7:0] mct);
        RCSN = 0; COMPE = 1; RA = a; MODE = md; ADDIN = add; MCT = mct;
        step(); idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        idle();
        RESETn = 0;
        step();
        chk("reset_readyn", READYN, 1'b1);
        chk("reset_psout", PSOUT, 24'd0);
        step();
        RESETn = 1;

        for (int r = 0; r < 128; r++) do_write(7'(r), rand256(), '1);
        for (int f = 0; f < 4; f++) do_feat(2'(f), rand256());

        // Full-row write and read-back.
        saved = {128'b0, {8{16'hA5A5}}};
        do_write(7'd0, saved, '1);
        do_read(7'd0);
        chk("r032_q", Q, saved);

        // Masked write keeps unmasked bits.
        do_write(7'd1, 256'hFF, '1);
        do_write(7'd1, 256'h00, 256'h0F);
        do_read(7'd1);
        chk("r033_q", Q, 256'hF0);

        // All-ones kernel and feature, single request, 4-cycle latency.
        for (int r = 0; r < 8; r++) do_write(7'(r), '1, '1);
        for (int f = 0; f < 4; f++) do_feat(2'(f), '1);
        do_req(7'd0, 2'b00, 24'd0, 8'd0);
        step(); step();
        chk("r034_early", READYN, 1'b1);
        step();
        chk("r034_rdy", READYN, 1'b0);
        chk("r034_ps", PSOUT, 24'd1024);
        chk("r034_q", {RES_OUT, SOUT}, 4'hF);

        // Back-to-back requests give consecutive pulses.
        for (int k = 0; k < 8; k++) begin
            if (k < 5) begin
                RCSN = 0; COMPE = 1; RA = 7'(k);
            end else idle();
            step();
            chk("r035_rdy", READYN, (k >= 3) ? 1'b0 : 1'b1);
            if (k >= 3) chk("r035_ps", PSOUT, 24'd1024);
        end
        idle();
        step();
        chk("hold_ps", PSOUT, 24'd1024);

        // 4-bit lane mode, single nonzero lane, then with a shift.
        do_write(7'd0, 256'h1, '1);
        for (int r = 1; r < 4; r++) do_write(7'(r), '0, '1);
        do_feat(2'd0, 256'h1);
        for (int f = 1; f < 4; f++) do_feat(2'(f), '0);
        do_req(7'd0, 2'b10, 24'd5, 8'd0);
        step(); step(); step();
        chk("r036_ps", PSOUT, 24'd6);
        chk("r036_q", {RES_OUT, SOUT}, 4'b0110);
        do_req(7'd0, 2'b10, 24'd5, 8'd1);
        step(); step(); step();
        chk("r036_q_sh", {RES_OUT, SOUT}, 4'b0011);

        // Same-row read/write returns old data; compute sees pre-write rows.
        for (int f = 0; f < 4; f++) do_feat(2'(f), rand256());
        saved = mem_m[9];
        RCSN = 0; COMPE = 0; RA = 7'd9; WCSN = 0; WEN = 0; WA = 7'd9; D = rand256(); M = '1;
        step(); idle();
        chk("r017_q", Q, saved);
        RCSN = 0; COMPE = 1; RA = 7'd8; MODE = 2'b11; WCSN = 0; WEN = 0; WA = 7'd9;
        D = rand256(); M = rand256(); FCSN = 0; FA = 2'd1; FD = rand256();
        step(); idle();
        for (int i = 0; i < 4; i++) step();

        // Random traffic.
        for (int i = 0; i < 120; i++) begin
            idle();
            if ($urandom_range(0, 2) == 0) begin
                WCSN = 0; WEN = 0; WA = 7'($urandom); D = rand256();
                M = ($urandom_range(0, 1) == 1) ? '1 : rand256();
            end
            if ($urandom_range(0, 3) == 0) begin
                FCSN = 0; FA = 2'($urandom); FD = rand256();
            end
            if ($urandom_range(0, 1) == 1) begin
                RCSN = 0; COMPE = 1'($urandom); RA = 7'($urandom);
            end
            rcsn_sec = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            MODE = 2'($urandom);
            ADDIN = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 40));
            MCT = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 20));
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) step();

        // Reset one cycle after a request: no pulse, writes and requests ignored.
        saved = mem_m[20];
        do_req(7'd4, 2'b00, 24'd3, 8'd0);
        RESETn = 0;
        WCSN = 0; WEN = 0; WA = 7'd20; D = ~saved; M = '1;
        RCSN = 0; COMPE = 1; RA = 7'd20;
        step(); idle();
        chk("r037_ps", PSOUT, 24'd0);
        RESETn = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r037_rdy", READYN, 1'b1);
        end
        do_read(7'd20);
        chk("r031_q", Q, saved);
        do_req(7'd20, 2'b01, 24'd0, 8'd2);
        for (int i = 0; i < 4; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
